// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: merges the W-stage pipeline write with a queued MDU write stream.
// Pipe writes take priority, and same-register pipe writes kill older queued MDU writes.
module grf_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pipe_we,
    input  logic [AW-1:0]    pipe_a3,
    input  logic [DW-1:0]    pipe_wd,
    input  logic [DW-1:0]    pipe_pc,
    input  logic             md_valid,
    output logic             md_ready,
    input  logic [AW-1:0]    md_a3,
    input  logic [DW-1:0]    md_wd,
    input  logic [DW-1:0]    md_pc,
    output logic             grf_we,
    output logic [AW-1:0]    grf_a3,
    output logic [DW-1:0]    grf_wd,
    output logic [DW-1:0]    grf_pc,
    output logic [2**AW-1:0] busy_mask,
    output logic             waw_drop
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    q_a3_q [DEPTH];
    logic [DW-1:0]    q_wd_q [DEPTH];
    logic [DW-1:0]    q_pc_q [DEPTH];
    logic [DEPTH-1:0] q_vld_q, q_vld_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             grf_we_q, grf_we_d;
    logic [AW-1:0]    grf_a3_q, grf_a3_d;
    logic [DW-1:0]    grf_wd_q, grf_wd_d;
    logic [DW-1:0]    grf_pc_q, grf_pc_d;
    logic             waw_drop_q, waw_drop_d;

    logic             pipe_issue, push, pop;
    logic [DEPTH-1:0] kill;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pipe_issue = pipe_we && (pipe_a3 != '0);
        md_ready   = reset && (count_q != CW'(DEPTH));
        push       = md_valid && md_ready && (md_a3 != '0);
        pop        = !pipe_issue && (count_q != '0);

        for (int i = 0; i < DEPTH; i++) begin
            kill[i] = pipe_issue && q_vld_q[i] && (q_a3_q[i] == pipe_a3);
        end

        // The incoming push is younger than the pipe write, so it is set after the kill.
        q_vld_d = q_vld_q & ~kill;
        if (pop)  q_vld_d[rd_ptr_q] = 1'b0;
        if (push) q_vld_d[wr_ptr_q] = 1'b1;

        wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (!push && pop) count_d = count_q - 1'b1;

        waw_drop_d = |kill;

        grf_we_d = 1'b0;
        grf_a3_d = grf_a3_q;
        grf_wd_d = grf_wd_q;
        grf_pc_d = grf_pc_q;
        if (pipe_issue) begin
            grf_we_d = 1'b1;
            grf_a3_d = pipe_a3;
            grf_wd_d = pipe_wd;
            grf_pc_d = pipe_pc;
        end else if (pop && q_vld_q[rd_ptr_q]) begin
            grf_we_d = 1'b1;
            grf_a3_d = q_a3_q[rd_ptr_q];
            grf_wd_d = q_wd_q[rd_ptr_q];
            grf_pc_d = q_pc_q[rd_ptr_q];
        end

        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld_q[i]) busy_mask[q_a3_q[i]] = 1'b1;
        end
        busy_mask[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_vld_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            grf_we_q   <= 1'b0;
            grf_a3_q   <= '0;
            grf_wd_q   <= '0;
            grf_pc_q   <= '0;
            waw_drop_q <= 1'b0;
        end else begin
            q_vld_q    <= q_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            grf_we_q   <= grf_we_d;
            grf_a3_q   <= grf_a3_d;
            grf_wd_q   <= grf_wd_d;
            grf_pc_q   <= grf_pc_d;
            waw_drop_q <= waw_drop_d;
        end
    end

    // NOTE: queue payload storage is not reset; the valid bits alone decide whether an entry is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            q_a3_q[wr_ptr_q] <= md_a3;
            q_wd_q[wr_ptr_q] <= md_wd;
            q_pc_q[wr_ptr_q] <= md_pc;
        end
    end

    assign grf_we   = grf_we_q;
    assign grf_a3   = grf_a3_q;
    assign grf_wd   = grf_wd_q;
    assign grf_pc   = grf_pc_q;
    assign waw_drop = waw_drop_q;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed, table-driven bench for grf_wb_arbiter, plus a hand-written mid-operation reset sequence.
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we, md_valid, md_ready;
    logic [4:0]  pipe_a3, md_a3, grf_a3;
    logic [31:0] pipe_wd, pipe_pc, md_wd, md_pc, grf_wd, grf_pc;
    logic        grf_we, waw_drop;
    logic [31:0] busy_mask;

    int checks = 0;
    int errors = 0;

    grf_wb_arbiter #(.DEPTH(2), .AW(5), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
        .md_valid(md_valid), .md_ready(md_ready), .md_a3(md_a3), .md_wd(md_wd), .md_pc(md_pc),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .busy_mask(busy_mask), .waw_drop(waw_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pwe;
        logic [4:0]  pa3;
        logic [31:0] pwd, ppc;
        logic        mv;
        logic [4:0]  ma3;
        logic [31:0] mwd, mpc;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd, pc, busy;
        logic        rdy, drop;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic pwe, input logic [4:0] pa3, input logic [31:0] pwd, input logic [31:0] ppc,
        input logic mv, input logic [4:0] ma3, input logic [31:0] mwd, input logic [31:0] mpc,
        input logic we, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc,
        input logic [31:0] busy, input logic rdy, input logic drop);
        vec_t v;
        v.pwe = pwe; v.pa3 = pa3; v.pwd = pwd; v.ppc = ppc;
        v.mv = mv; v.ma3 = ma3; v.mwd = mwd; v.mpc = mpc;
        v.we = we; v.a3 = a3; v.wd = wd; v.pc = pc;
        v.busy = busy; v.rdy = rdy; v.drop = drop;
        return v;
    endfunction

    function automatic logic [31:0] bit_of(input int n);
        return 32'd1 << n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pa3, input logic [31:0] pwd,
                         input logic [31:0] ppc, input logic mv, input logic [4:0] ma3,
                         input logic [31:0] mwd, input logic [31:0] mpc);
        pipe_we = pwe; pipe_a3 = pa3; pipe_wd = pwd; pipe_pc = ppc;
        md_valid = mv; md_a3 = ma3; md_wd = mwd; md_pc = mpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           pwe pa3  pwd      ppc      mv ma3 mwd     mpc     | we a3  wd      pc      busy                       rdy drop
        tbl[0]  = mk(1, 5,  32'h1234, 32'h100, 0, 0,  32'h0,  32'h0,   1, 5,  32'h1234, 32'h100, 32'h0,                  1, 0);
        tbl[1]  = mk(0, 0,  32'h0,    32'h0,   1, 8,  32'hAA, 32'h200, 0, 5,  32'h1234, 32'h100, bit_of(8),              1, 0);
        tbl[2]  = mk(0, 0,  32'h0,    32'h0,   0, 0,  32'h0,  32'h0,   1, 8,  32'hAA,   32'h200, 32'h0,                  1, 0);
        tbl[3]  = mk(1, 10, 32'h11,   32'h300, 1, 3,  32'h33, 32'h310, 1, 10, 32'h11,   32'h300, bit_of(3),              1, 0);
        tbl[4]  = mk(1, 11, 32'h22,   32'h304, 1, 4,  32'h44, 32'h320, 1, 11, 32'h22,   32'h304, bit_of(3) | bit_of(4),  0, 0);
        tbl[5]  = mk(1, 12, 32'h55,   32'h308, 1, 9,  32'h99, 32'h330, 1, 12, 32'h55,   32'h308, bit_of(3) | bit_of(4),  0, 0);
        tbl[6]  = mk(0, 0,  32'h0,    32'h0,   0, 0,  32'h0,  32'h0,   1, 3,  32'h33,   32'h310, bit_of(4),              1, 0);
        tbl[7]  = mk(0, 0,  32'h0,    32'h0,   0, 0,  32'h0,  32'h0,   1, 4,  32'h44,   32'h320, 32'h0,                  1, 0);
        tbl[8]  = mk(0, 0,  32'h0,    32'h0,   1, 7,  32'h77, 32'h400, 0, 4,  32'h44,   32'h320, bit_of(7),              1, 0);
        tbl[9]  = mk(1, 7,  32'h70,   32'h410, 0, 0,  32'h0,  32'h0,   1, 7,  32'h70,   32'h410, 32'h0,                  1, 1);
        tbl[10] = mk(0, 0,  32'h0,    32'h0,   0, 0,  32'h0,  32'h0,   0, 7,  32'h70,   32'h410, 32'h0,                  1, 0);
        tbl[11] = mk(0, 0,  32'h0,    32'h0,   0, 0,  32'h0,  32'h0,   0, 7,  32'h70,   32'h410, 32'h0,                  1, 0);
        tbl[12] = mk(0, 0,  32'h0,    32'h0,   1, 6,  32'h66, 32'h500, 0, 7,  32'h70,   32'h410, bit_of(6),              1, 0);
        tbl[13] = mk(1, 6,  32'h60,   32'h510, 1, 6,  32'h61, 32'h520, 1, 6,  32'h60,   32'h510, bit_of(6),              0, 1);
        tbl[14] = mk(0, 0,  32'h0,    32'h0,   0, 0,  32'h0,  32'h0,   0, 6,  32'h60,   32'h510, bit_of(6),              1, 0);
        tbl[15] = mk(0, 0,  32'h0,    32'h0,   0, 0,  32'h0,  32'h0,   1, 6,  32'h61,   32'h520, 32'h0,                  1, 0);
        tbl[16] = mk(1, 0,  32'hF0,   32'h600, 1, 0,  32'hF1, 32'h610, 0, 6,  32'h61,   32'h520, 32'h0,                  1, 0);
        tbl[17] = mk(1, 0,  32'hF2,   32'h604, 1, 0,  32'hF3, 32'h614, 0, 6,  32'h61,   32'h520, 32'h0,                  1, 0);
        tbl[18] = mk(0, 0,  32'h0,    32'h0,   1, 2,  32'h22, 32'h700, 0, 6,  32'h61,   32'h520, bit_of(2),              1, 0);
        tbl[19] = mk(1, 0,  32'hEE,   32'h704, 0, 0,  32'h0,  32'h0,   1, 2,  32'h22,   32'h700, 32'h0,                  1, 0);
        tbl[20] = mk(0, 0,  32'h0,    32'h0,   1, 13, 32'hD,  32'h800, 0, 2,  32'h22,   32'h700, bit_of(13),             1, 0);
        tbl[21] = mk(0, 0,  32'h0,    32'h0,   1, 14, 32'hE,  32'h810, 1, 13, 32'hD,    32'h800, bit_of(14),             1, 0);
        tbl[22] = mk(0, 0,  32'h0,    32'h0,   0, 0,  32'h0,  32'h0,   1, 14, 32'hE,    32'h810, 32'h0,                  1, 0);

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        check("reset grf_we",    64'(grf_we), 64'd0);
        check("reset grf_a3",    64'(grf_a3), 64'd0);
        check("reset grf_wd",    64'(grf_wd), 64'd0);
        check("reset grf_pc",    64'(grf_pc), 64'd0);
        check("reset busy_mask", 64'(busy_mask), 64'd0);
        check("reset waw_drop",  64'(waw_drop), 64'd0);
        check("reset md_ready",  64'(md_ready), 64'd0);
        reset = 1'b1;
        #1;
        check("release md_ready", 64'(md_ready), 64'd1);

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].pwe, tbl[i].pa3, tbl[i].pwd, tbl[i].ppc,
                  tbl[i].mv, tbl[i].ma3, tbl[i].mwd, tbl[i].mpc);
            tick();
            check($sformatf("v%0d grf_we", i),    64'(grf_we),    64'(tbl[i].we));
            check($sformatf("v%0d grf_a3", i),    64'(grf_a3),    64'(tbl[i].a3));
            check($sformatf("v%0d grf_wd", i),    64'(grf_wd),    64'(tbl[i].wd));
            check($sformatf("v%0d grf_pc", i),    64'(grf_pc),    64'(tbl[i].pc));
            check($sformatf("v%0d busy_mask", i), 64'(busy_mask), 64'(tbl[i].busy));
            check($sformatf("v%0d md_ready", i),  64'(md_ready),  64'(tbl[i].rdy));
            check($sformatf("v%0d waw_drop", i),  64'(waw_drop),  64'(tbl[i].drop));
        end

        // Fill the queue behind a busy pipe, then reset asynchronously mid-cycle.
        drive(1, 1, 32'h1, 32'h900, 1, 20, 32'h20, 32'h910);
        tick();
        drive(1, 1, 32'h2, 32'h904, 1, 21, 32'h21, 32'h920);
        tick();
        check("full busy_mask", 64'(busy_mask), 64'(bit_of(20) | bit_of(21)));
        check("full md_ready",  64'(md_ready),  64'd0);
        check("full grf_we",    64'(grf_we),    64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        #1;
        check("async grf_we",    64'(grf_we),    64'd0);
        check("async grf_a3",    64'(grf_a3),    64'd0);
        check("async busy_mask", 64'(busy_mask), 64'd0);
        check("async md_ready",  64'(md_ready),  64'd0);
        #3;
        reset = 1'b1;
        #1;
        check("post-reset md_ready", 64'(md_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post-reset %0d grf_we", i),    64'(grf_we),    64'd0);
            check($sformatf("post-reset %0d busy_mask", i), 64'(busy_mask), 64'd0);
            check($sformatf("post-reset %0d md_ready", i),  64'(md_ready),  64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
